mpu_window_tx: RTL and testbench

MPU_WINDOW_TX -- requirements
Module: mpu_window_tx

---
 rtl/mpu_window_tx_pkg.sv | 24 ++
 rtl/mpu_window_tx_if.sv | 21 ++
 rtl/mpu_sample_buf.sv | 27 ++
 rtl/mpu_window_tx.sv | 144 ++++++++++++++
 tb/tb_mpu_window_tx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_window_tx_pkg.sv
// Shared constants, FSM encoding and helpers for the MPU window transmitter.
// Everything that the top, the buffer and the bench must agree on lives here.
package mpu_window_tx_pkg;

    localparam int N_SAMPLES_DEF = 30;
    localparam int VALID_GAP_DEF = 1;

    localparam int RAW_W     = 16;
    localparam int OUT_W     = 32;
    localparam int BUF_DEPTH = 32;
    localparam int BUF_AW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_SEND     = 2'd2,
        ST_WAIT_RDY = 2'd3
    } state_t;

    function automatic logic [OUT_W-1:0] sign_ext(input logic [RAW_W-1:0] raw);
        return {{(OUT_W-RAW_W){raw[RAW_W-1]}}, raw};
    endfunction

endpackage

// File: rtl/mpu_window_tx_if.sv
// Sample stream from the window transmitter to the gesture recognizer.
// The master presents samples; the slave answers with ready once its result is out.
interface mpu_window_tx_if;

    logic [mpu_window_tx_pkg::OUT_W-1:0] mpu_valor;
    logic                                mpu_valid;
    logic                                ready;

    modport master (
        output mpu_valor,
        output mpu_valid,
        input  ready
    );

    modport slave (
        input  mpu_valor,
        input  mpu_valid,
        output ready
    );

endinterface

// File: rtl/mpu_sample_buf.sv
// Window sample store: synchronous write, registered read, no reset so that
// synthesis can map it onto distributed or block RAM.
module mpu_sample_buf
    import mpu_window_tx_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int WIDTH = OUT_W,
    parameter int AW    = BUF_AW
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mpu_window_tx.sv
// Captures one gesture window of raw MPU samples while mov is high, then
// streams the window to the recognizer and waits for its ready.
module mpu_window_tx
    import mpu_window_tx_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int VALID_GAP = VALID_GAP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mov,
    input  logic             raw_valid,
    input  logic [RAW_W-1:0] raw_z,
    mpu_window_tx_if.master  rec,
    output logic             busy,
    output logic             overrun
);

    // Counters only ever reach N_SAMPLES-1 as an address; one spare code keeps
    // the write counter from wrapping on its final increment.
    localparam int CW = (N_SAMPLES < 2) ? 1 : $clog2(N_SAMPLES + 1);
    localparam int GW = (VALID_GAP < 1) ? 1 : $clog2(VALID_GAP + 2);

    state_t           state_reg;
    logic [CW-1:0]    wr_cnt_reg;
    logic [CW-1:0]    rd_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             mov_d_reg;
    logic             mov_seen_low_reg;
    logic             mpu_valid_reg;
    logic [OUT_W-1:0] mpu_valor_reg;
    logic             overrun_reg;

    logic              mov_rise;
    logic              wr_en;
    logic              fire;
    logic              last_rd;
    logic [BUF_AW-1:0] wr_addr;
    logic [BUF_AW-1:0] rd_addr;
    logic [OUT_W-1:0]  rd_data;

    // A level that was already high when reset released is not an edge.
    assign mov_rise = mov && !mov_d_reg && mov_seen_low_reg;
    assign wr_en    = (state_reg == ST_CAPTURE) && mov && raw_valid;
    assign wr_addr  = BUF_AW'(wr_cnt_reg);
    assign fire     = (state_reg == ST_SEND) && (gap_cnt_reg == '0);
    assign last_rd  = (rd_cnt_reg == CW'(N_SAMPLES - 1));

    // Look one sample ahead on a pulse so the next value is already in the
    // read register, whatever the gap; never address past the last sample.
    always_comb begin
        rd_addr = BUF_AW'(rd_cnt_reg);
        if (fire && !last_rd) begin
            rd_addr = BUF_AW'(rd_cnt_reg + CW'(1));
        end
    end

    mpu_sample_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (OUT_W),
        .AW    (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (sign_ext(raw_z)),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            wr_cnt_reg       <= '0;
            rd_cnt_reg       <= '0;
            gap_cnt_reg      <= '0;
            mov_d_reg        <= 1'b0;
            mov_seen_low_reg <= 1'b0;
            mpu_valid_reg    <= 1'b0;
            mpu_valor_reg    <= '0;
            overrun_reg      <= 1'b0;
        end else begin
            mov_d_reg     <= mov;
            mpu_valid_reg <= 1'b0;
            if (!mov) begin
                mov_seen_low_reg <= 1'b1;
            end
            if (raw_valid && mov &&
                (state_reg == ST_SEND || state_reg == ST_WAIT_RDY)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (mov_rise) begin
                        state_reg  <= ST_CAPTURE;
                        wr_cnt_reg <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (!mov) begin
                        state_reg <= ST_IDLE;
                    end else if (raw_valid) begin
                        wr_cnt_reg <= wr_cnt_reg + CW'(1);
                        if (wr_cnt_reg == CW'(N_SAMPLES - 1)) begin
                            state_reg   <= ST_SEND;
                            rd_cnt_reg  <= '0;
                            // One priming cycle lets sample 0 reach the read register.
                            gap_cnt_reg <= GW'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (gap_cnt_reg != '0) begin
                        gap_cnt_reg <= gap_cnt_reg - GW'(1);
                    end else begin
                        mpu_valid_reg <= 1'b1;
                        mpu_valor_reg <= rd_data;
                        gap_cnt_reg   <= GW'(VALID_GAP);
                        if (last_rd) begin
                            state_reg <= ST_WAIT_RDY;
                        end else begin
                            rd_cnt_reg <= rd_cnt_reg + CW'(1);
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (rec.ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rec.mpu_valid = mpu_valid_reg;
    assign rec.mpu_valor = mpu_valor_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_mpu_window_tx.sv
// Directed bench for mpu_window_tx: full windows, aborted window, extreme
// values, ready stall, overrun stickiness and reset in the middle of a stream.
module tb_mpu_window_tx;
    import mpu_window_tx_pkg::*;

    localparam int N = N_SAMPLES_DEF;
    localparam int G = VALID_GAP_DEF;

    localparam logic signed [15:0] ZPAT [30] = '{
        -16'sd865, -16'sd854, -16'sd685, -16'sd520, -16'sd410, -16'sd333,
        -16'sd280, -16'sd251, -16'sd240, -16'sd262, -16'sd301, -16'sd355,
        -16'sd420, -16'sd498, -16'sd560, -16'sd611, -16'sd650, -16'sd702,
        -16'sd748, -16'sd790, -16'sd812, -16'sd830, -16'sd801, -16'sd770,
        -16'sd733, -16'sd702, -16'sd668, -16'sd640, -16'sd612, -16'sd550
    };

    logic        clk;
    logic        reset;
    logic        mov;
    logic        raw_valid;
    logic [15:0] raw_z;
    logic        busy;
    logic        overrun;

    mpu_window_tx_if rec_if ();

    mpu_window_tx #(
        .N_SAMPLES (N),
        .VALID_GAP (G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mov       (mov),
        .raw_valid (raw_valid),
        .raw_z     (raw_z),
        .rec       (rec_if),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0]       got_q [$];
    int                cyc_q [$];
    int                glitches = 0;
    logic [31:0]       prev_valor = '0;
    logic signed [15:0] samp [30];
    int                cap_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Records every pulse and watches that mpu_valor holds between pulses.
    always @(negedge clk) begin
        if (reset) begin
            if (rec_if.mpu_valid) begin
                got_q.push_back(rec_if.mpu_valor);
                cyc_q.push_back(cyc);
                $display("pulse %0d cyc=%0d valor=%h", got_q.size(), cyc, rec_if.mpu_valor);
            end else if (rec_if.mpu_valor !== prev_valor) begin
                glitches++;
            end
        end
        prev_valor = rec_if.mpu_valor;
    end

    // Leaves mov high; cap_cyc is the cycle count just after the final store edge.
    task automatic run_window();
        got_q.delete();
        cyc_q.delete();
        @(negedge clk) mov = 1'b0;
        @(negedge clk) mov = 1'b0;
        @(negedge clk) mov = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            raw_valid = 1'b1;
            raw_z     = samp[i];
        end
        @(negedge clk);
        raw_valid = 1'b0;
        cap_cyc   = cyc;
        $display("window captured at cyc=%0d", cap_cyc);
    endtask

    task automatic collect(input string tag);
        int waited = 0;
        int bad_gaps = 0;
        logic [31:0] exp_v;
        while (got_q.size() < N && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        repeat (10) @(negedge clk);
        check($sformatf("%s_count", tag), got_q.size(), N);
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            exp_v = {{16{samp[i][15]}}, samp[i]};
            check($sformatf("%s_v%0d", tag, i), got_q[i], exp_v);
        end
        if (cyc_q.size() > 0)
            check($sformatf("%s_latency", tag), cyc_q[0] - cap_cyc, 2);
        for (int i = 1; i < cyc_q.size(); i++)
            if (cyc_q[i] - cyc_q[i-1] != G + 1) bad_gaps++;
        check($sformatf("%s_gaps", tag), bad_gaps, 0);
        check($sformatf("%s_busy_wait", tag), busy, 1'b1);
    endtask

    task automatic pulse_ready();
        @(negedge clk) rec_if.ready = 1'b1;
        @(negedge clk) rec_if.ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int n_before;
        reset        = 1'b0;
        mov          = 1'b0;
        raw_valid    = 1'b0;
        raw_z        = '0;
        rec_if.ready = 1'b0;
        for (int i = 0; i < N; i++) samp[i] = ZPAT[i];

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rec_if.mpu_valid, 1'b0);
        check("rst_valor", rec_if.mpu_valor, 32'h0);
        check("rst_overrun", overrun, 1'b0);
        @(negedge clk) reset = 1'b1;

        // Full window with the Z pattern, then a long ready stall with mov held.
        run_window();
        collect("a");
        n_before = got_q.size();
        repeat (200) @(negedge clk);
        check("a_stall_busy", busy, 1'b1);
        check("a_stall_nopulse", got_q.size(), n_before);
        pulse_ready();
        check("a_ready_idle", busy, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            raw_valid = i[0];
            raw_z     = 16'h1111;
        end
        @(negedge clk) raw_valid = 1'b0;
        check("a_mov_held_idle", busy, 1'b0);
        check("a_mov_held_nopulse", got_q.size(), n_before);
        check("a_overrun", overrun, 1'b0);

        // Partial window aborted by mov falling.
        got_q.delete();
        cyc_q.delete();
        @(negedge clk) mov = 1'b0;
        @(negedge clk) mov = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            raw_valid = 1'b1;
            raw_z     = samp[i];
        end
        @(negedge clk);
        raw_valid = 1'b0;
        check("b_busy_before_fall", busy, 1'b1);
        mov = 1'b0;
        @(negedge clk);
        check("b_busy_after_fall", busy, 1'b0);
        repeat (80) @(negedge clk);
        check("b_nopulse", got_q.size(), 0);
        check("b_overrun", overrun, 1'b0);

        // Extreme values inside a window, plus a dropped sample during SEND.
        samp[5] = -16'sd32768;
        samp[6] = 16'sd32767;
        run_window();
        cnt = 0;
        while (got_q.size() < 3 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        raw_valid = 1'b1;
        raw_z     = 16'h04D2;
        @(negedge clk) raw_valid = 1'b0;
        check("c_overrun_set", overrun, 1'b1);
        collect("c");
        if (got_q.size() > 6) begin
            check("c_min", got_q[5], 32'hFFFF8000);
            check("c_max", got_q[6], 32'h00007FFF);
        end
        pulse_ready();

        // Overrun survives a clean window.
        for (int i = 0; i < N; i++) samp[i] = ZPAT[i];
        run_window();
        collect("d");
        check("d_overrun_sticky", overrun, 1'b1);
        pulse_ready();

        // Reset during the 10th pulse.
        run_window();
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 10; i++) begin
            @(posedge clk);
            #1;
            if (rec_if.mpu_valid) cnt++;
        end
        check("e_tenth_pulse", cnt, 10);
        reset = 1'b0;
        mov   = 1'b0;
        #1;
        check("e_rst_valid", rec_if.mpu_valid, 1'b0);
        check("e_rst_busy", busy, 1'b0);
        check("e_rst_overrun", overrun, 1'b0);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        got_q.delete();
        cyc_q.delete();
        repeat (5) @(negedge clk);
        check("e_nopulse_after", got_q.size(), 0);

        // Full window after the abort.
        run_window();
        collect("f");
        pulse_ready();
        check("f_idle", busy, 1'b0);
        check("hold_between_pulses", glitches, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
